// File: rtl/i2c_slave_read_bit.sv
// ============================================================================
// i2c_slave_read_bit : samples one I2C data bit during SCL high, reports on fall
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_slave_read_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic scl,
  input  logic sda,
  output logic data,
  output logic error,
  output logic finish
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state_q, state_d;
  logic       data_q, data_d;
  logic       error_q, error_d;
  logic       finish_q, finish_d;
  logic       scl_q;
  logic       scl_fall;

  assign scl_fall = scl_q & ~scl;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    error_d  = error_q;
    finish_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          if (scl) begin
            data_d  = sda;
            error_d = 1'b0;
            state_d = BUSY;
          end else begin
            // Enable outside the high phase: report an invalid bit at once
            finish_d = 1'b1;
            error_d  = 1'b1;
          end
        end
      end
      BUSY: begin
        // A low SCL takes priority over any simultaneous SDA movement
        if (scl_fall || !scl) begin
          finish_d = 1'b1;
          error_d  = 1'b0;
          state_d  = IDLE;
        end else if (sda != data_q) begin
          finish_d = 1'b1;
          error_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= 1'b0;
      error_q  <= 1'b0;
      finish_q <= 1'b0;
      scl_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      error_q  <= error_d;
      finish_q <= finish_d;
      scl_q    <= scl;
    end
  end

  assign data   = data_q;
  assign error  = error_q;
  assign finish = finish_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_read_bit.sv
// ============================================================================
// tb_i2c_slave_read_bit : directed scoreboard bench for i2c_slave_read_bit
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_slave_read_bit;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic scl;
  logic sda;
  logic data;
  logic error;
  logic finish;

  logic [1:0] sb[$];
  int vectors     = 0;
  int miscompares = 0;
  int n_finish    = 0;

  always #5 clk = ~clk;

  i2c_slave_read_bit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .scl    (scl),
    .sda    (sda),
    .data   (data),
    .error  (error),
    .finish (finish)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every finish pulse must match the oldest expected {data,error}
  always @(negedge clk) begin
    if (rst_n === 1'b1 && finish === 1'b1) begin
      n_finish++;
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_finish: observed finish=1 expected no finish (t=%0t)", $time);
      end
      if (sb.size() != 0) begin
        logic [1:0] e;
        e = sb.pop_front();
        chk("sb_data", data, e[1]);
        chk("sb_error", error, e[0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One 8-clk SCL period: 4 high / 4 low, enable 1 clk after the rise
  task automatic bit_period(input logic b, input logic nb);
    cyc(); scl = 1'b1;
    cyc(); enable = 1'b1; sb.push_back({b, 1'b0});
    cyc(); enable = 1'b0;
    cyc();
    cyc(); scl = 1'b0;
    cyc(); sda = nb;
    cyc();
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pat;
    int          base;
    pat    = 32'h13579BDF;
    rst_n  = 1'b0;
    scl    = 1'b1;
    sda    = 1'b0;
    enable = 1'b0;
    repeat (3) cyc();
    chk("reset_data", data, 1'b0);
    chk("reset_error", error, 1'b0);
    chk("reset_finish", finish, 1'b0);
    rst_n = 1'b1;
    cyc(); scl = 1'b0;
    cyc();

    // Stream of 32 bits, MSB first
    sda = pat[31];
    for (int i = 31; i >= 0; i--) begin
      bit_period(pat[i], (i > 0) ? pat[i-1] : 1'b0);
    end
    chk_int("stream_finish_count", n_finish, 32);
    chk_int("stream_sb_empty", sb.size(), 0);

    // START condition: SDA 1->0 while SCL high
    sda = 1'b1;
    cyc(); scl = 1'b1;
    cyc(); enable = 1'b1; sb.push_back(2'b11);
    cyc(); enable = 1'b0; sda = 1'b0;
    cyc();
    @(negedge clk);
    chk("start_finish", finish, 1'b1);
    chk("start_error", error, 1'b1);
    cyc();
    cyc();
    chk("start_data_hold", data, 1'b1);
    chk("start_error_hold", error, 1'b1);
    chk("start_finish_low", finish, 1'b0);
    cyc(); scl = 1'b0;
    cyc();
    cyc();

    // Enable while SCL low: immediate error, data unchanged, stay IDLE
    cyc(); enable = 1'b1; sb.push_back(2'b11);
    cyc(); enable = 1'b0;
    @(negedge clk);
    chk("lowen_finish", finish, 1'b1);
    chk("lowen_error", error, 1'b1);
    chk("lowen_data", data, 1'b1);
    cyc();
    @(negedge clk);
    chk("lowen_pulse_width", finish, 1'b0);
    cyc(); scl = 1'b1;
    repeat (3) cyc();
    scl = 1'b0;
    repeat (3) cyc();

    // Second enable while BUSY is ignored
    sda = 1'b0;
    cyc(); scl = 1'b1;
    cyc(); enable = 1'b1; sb.push_back(2'b00);
    cyc(); enable = 1'b0;
    cyc(); enable = 1'b1;
    cyc(); enable = 1'b0;
    cyc(); scl = 1'b0;
    cyc();
    @(negedge clk);
    chk("busyen_finish", finish, 1'b1);
    cyc();
    cyc();

    // Reset in the middle of a bit
    sda = 1'b1;
    cyc(); scl = 1'b1;
    cyc(); enable = 1'b1;
    cyc(); enable = 1'b0;
    cyc();
    chk("prereset_data", data, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midreset_data", data, 1'b0);
    chk("midreset_error", error, 1'b0);
    chk("midreset_finish", finish, 1'b0);
    cyc(); scl = 1'b0;
    cyc();
    cyc(); rst_n = 1'b1;
    cyc();
    cyc();
    bit_period(1'b1, 1'b0);

    // Clock stretching: SCL high 20 clk after enable
    cyc(); scl = 1'b1;
    cyc(); enable = 1'b1; sb.push_back(2'b00);
    base = n_finish;
    cyc(); enable = 1'b0;
    repeat (19) cyc();
    chk_int("stretch_no_early_finish", n_finish, base);
    scl = 1'b0;
    cyc();
    @(negedge clk);
    chk("stretch_finish", finish, 1'b1);
    chk("stretch_error", error, 1'b0);
    cyc();
    cyc();

    repeat (4) cyc();
    chk_int("final_sb_empty", sb.size(), 0);
    chk_int("final_finish_count", n_finish, 37);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
